// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one uart_transmitter among
// NUM_REQ byte requesters, with frame pacing and an optional idle gap.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 12,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                 clock_tx,
  input  logic                 reset_tx,
  input  logic [NUM_REQ-1:0]   req_tx,
  input  logic [8*NUM_REQ-1:0] data_req_tx,
  output logic [NUM_REQ-1:0]   grant_tx,
  output logic [2:0]           grant_id_tx,
  output logic                 tx_start,
  output logic [7:0]           data_in_tx,
  output logic                 busy_tx,
  output logic                 done_tx
);

  localparam int CMAX =
    (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] FRAME_LD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0] PTR_RST = 3'(NUM_REQ - 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [2:0]          ptr_q;
  logic [2:0]          ptr_d;

  logic [NUM_REQ-1:0]  grant_d;
  logic [2:0]          id_d;
  logic                start_d;
  logic [7:0]          data_d;
  logic                busy_d;
  logic                done_d;

  logic                win_vld;
  logic [2:0]          win;
  logic [IW-1:0]       idx;
  logic [7:0]          win_byte;
  logic [NUM_REQ-1:0]  win_oh;
  logic                launch;

  // first requester strictly after the pointer, wrapping
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && req_tx[idx]) begin
        win_vld = 1'b1;
        win     = 3'(idx);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    win_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) begin
        win_byte  = data_req_tx[8*i +: 8];
        win_oh[i] = 1'b1;
      end
    end
  end

  // frame/gap terminal edges double as arbitration edges
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    id_d    = grant_id_tx;
    start_d = 1'b0;
    data_d  = data_in_tx;
    busy_d  = busy_tx;
    done_d  = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        launch = win_vld;
      end
      FRAME: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            launch  = win_vld;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          launch  = win_vld;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (launch) begin
      state_d = FRAME;
      cnt_d   = FRAME_LD;
      ptr_d   = win;
      grant_d = win_oh;
      id_d    = win;
      start_d = 1'b1;
      data_d  = win_byte;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clock_tx or negedge reset_tx) begin
    if (!reset_tx) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= PTR_RST;
      grant_tx    <= '0;
      grant_id_tx <= '0;
      tx_start    <= 1'b0;
      data_in_tx  <= 8'h00;
      busy_tx     <= 1'b0;
      done_tx     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      grant_tx    <= grant_d;
      grant_id_tx <= id_d;
      tx_start    <= start_d;
      data_in_tx  <= data_d;
      busy_tx     <= busy_d;
      done_tx     <= done_d;
    end
  end

endmodule
